// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with MEM/WB operand forwarding and load-use bubble insertion; latency 1 cycle.
// Backpressure: Stall_D holds PC/decode for one cycle on a load-use hazard; Flush_E overrides it.
module id_ex_stage #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 5,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     Valid_D,
    input  logic [ADDRESS_WIDTH-1:0] AD1_D,
    input  logic [ADDRESS_WIDTH-1:0] AD2_D,
    input  logic [DATA_WIDTH-1:0]    RD1_D,
    input  logic [DATA_WIDTH-1:0]    RD2_D,
    input  logic [ADDRESS_WIDTH-1:0] AD3_D,
    input  logic                     RegWrite_D,
    input  logic                     MemRead_D,
    input  logic [ADDRESS_WIDTH-1:0] AD3_M,
    input  logic                     RegWrite_M,
    input  logic [DATA_WIDTH-1:0]    ALUout_M,
    input  logic [ADDRESS_WIDTH-1:0] AD3_W,
    input  logic                     RegWrite_W,
    input  logic [DATA_WIDTH-1:0]    WD3_W,
    input  logic                     Flush_E,
    output logic                     Valid_E,
    output logic [DATA_WIDTH-1:0]    SrcA_E,
    output logic [DATA_WIDTH-1:0]    SrcB_E,
    output logic [ADDRESS_WIDTH-1:0] AD3_E,
    output logic                     RegWrite_E,
    output logic                     MemRead_E,
    output logic                     Stall_D,
    output logic [CNT_WIDTH-1:0]     StallCount
);

    typedef struct packed {
        logic                     vld;
        logic [ADDRESS_WIDTH-1:0] ad3;
        logic                     reg_write;
        logic                     mem_read;
        logic [DATA_WIDTH-1:0]    src_a;
        logic [DATA_WIDTH-1:0]    src_b;
    } ex_t;

    ex_t                  ex_q;
    ex_t                  ex_d;
    logic [DATA_WIDTH-1:0] fwd_a;
    logic [DATA_WIDTH-1:0] fwd_b;
    logic                  hz;
    logic [CNT_WIDTH-1:0]  stall_cnt;

    // MEM is younger than WB, so its result takes precedence; x0 is hardwired zero.
    always_comb begin
        fwd_a = RD1_D;
        if (RegWrite_M && (AD3_M != '0) && (AD3_M == AD1_D))
            fwd_a = ALUout_M;
        else if (RegWrite_W && (AD3_W != '0) && (AD3_W == AD1_D))
            fwd_a = WD3_W;

        fwd_b = RD2_D;
        if (RegWrite_M && (AD3_M != '0) && (AD3_M == AD2_D))
            fwd_b = ALUout_M;
        else if (RegWrite_W && (AD3_W != '0) && (AD3_W == AD2_D))
            fwd_b = WD3_W;
    end

    assign hz = Valid_D && ex_q.vld && ex_q.mem_read && (ex_q.ad3 != '0) &&
                ((ex_q.ad3 == AD1_D) || (ex_q.ad3 == AD2_D));
    assign Stall_D = hz && !Flush_E;

    always_comb begin
        ex_d = '0;
        if (!Flush_E && !Stall_D) begin
            ex_d.vld       = Valid_D;
            ex_d.ad3       = AD3_D;
            ex_d.reg_write = RegWrite_D && Valid_D;
            ex_d.mem_read  = MemRead_D && Valid_D;
            ex_d.src_a     = fwd_a;
            ex_d.src_b     = fwd_b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ex_q <= '0;
        else
            ex_q <= ex_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt <= '0;
        else if (Stall_D && (stall_cnt != '1))
            stall_cnt <= stall_cnt + 1'b1;
    end

    assign Valid_E    = ex_q.vld;
    assign SrcA_E     = ex_q.src_a;
    assign SrcB_E     = ex_q.src_b;
    assign AD3_E      = ex_q.ad3;
    assign RegWrite_E = ex_q.reg_write;
    assign MemRead_E  = ex_q.mem_read;
    assign StallCount = stall_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: vector table plus reset and stall-counter saturation sequences.
module tb_id_ex_stage;

    localparam int DW  = 32;
    localparam int AW  = 5;
    localparam int CW  = 16;
    localparam int CWS = 4;
    localparam int NV  = 17;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          Valid_D;
    logic [AW-1:0] AD1_D, AD2_D, AD3_D, AD3_M, AD3_W;
    logic [DW-1:0] RD1_D, RD2_D, ALUout_M, WD3_W;
    logic          RegWrite_D, MemRead_D, RegWrite_M, RegWrite_W, Flush_E;
    logic          Valid_E, RegWrite_E, MemRead_E, Stall_D;
    logic [DW-1:0] SrcA_E, SrcB_E;
    logic [AW-1:0] AD3_E;
    logic [CW-1:0] StallCount;

    logic           s_valid_e, s_regwrite_e, s_memread_e, s_stall_d;
    logic [DW-1:0]  s_srca_e, s_srcb_e;
    logic [AW-1:0]  s_ad3_e;
    logic [CWS-1:0] s_stallcount;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n), .Valid_D(Valid_D), .AD1_D(AD1_D), .AD2_D(AD2_D),
        .RD1_D(RD1_D), .RD2_D(RD2_D), .AD3_D(AD3_D), .RegWrite_D(RegWrite_D),
        .MemRead_D(MemRead_D), .AD3_M(AD3_M), .RegWrite_M(RegWrite_M), .ALUout_M(ALUout_M),
        .AD3_W(AD3_W), .RegWrite_W(RegWrite_W), .WD3_W(WD3_W), .Flush_E(Flush_E),
        .Valid_E(Valid_E), .SrcA_E(SrcA_E), .SrcB_E(SrcB_E), .AD3_E(AD3_E),
        .RegWrite_E(RegWrite_E), .MemRead_E(MemRead_E), .Stall_D(Stall_D),
        .StallCount(StallCount)
    );

    // Narrow-counter copy sharing all inputs so saturation is reachable in a few cycles.
    id_ex_stage #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .CNT_WIDTH(CWS)) dut_small (
        .clk(clk), .rst_n(rst_n), .Valid_D(Valid_D), .AD1_D(AD1_D), .AD2_D(AD2_D),
        .RD1_D(RD1_D), .RD2_D(RD2_D), .AD3_D(AD3_D), .RegWrite_D(RegWrite_D),
        .MemRead_D(MemRead_D), .AD3_M(AD3_M), .RegWrite_M(RegWrite_M), .ALUout_M(ALUout_M),
        .AD3_W(AD3_W), .RegWrite_W(RegWrite_W), .WD3_W(WD3_W), .Flush_E(Flush_E),
        .Valid_E(s_valid_e), .SrcA_E(s_srca_e), .SrcB_E(s_srcb_e), .AD3_E(s_ad3_e),
        .RegWrite_E(s_regwrite_e), .MemRead_E(s_memread_e), .Stall_D(s_stall_d),
        .StallCount(s_stallcount)
    );

    typedef struct packed {
        logic          vld;
        logic [AW-1:0] ad1;
        logic [AW-1:0] ad2;
        logic [DW-1:0] rd1;
        logic [DW-1:0] rd2;
        logic [AW-1:0] ad3;
        logic          rw;
        logic          mr;
        logic [AW-1:0] ad3_m;
        logic          rw_m;
        logic [DW-1:0] alu_m;
        logic [AW-1:0] ad3_w;
        logic          rw_w;
        logic [DW-1:0] wd3_w;
        logic          flush;
        logic          x_stall;
        logic          x_vld;
        logic [DW-1:0] x_a;
        logic [DW-1:0] x_b;
        logic [AW-1:0] x_ad3;
        logic          x_rw;
        logic          x_mr;
        logic [CW-1:0] x_cnt;
    } vec_t;

    vec_t vecs [0:NV-1];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic vld, input logic [AW-1:0] ad1, input logic [AW-1:0] ad2,
                         input logic [AW-1:0] ad3, input logic mr);
        Valid_D = vld; AD1_D = ad1; AD2_D = ad2; RD1_D = 32'h11; RD2_D = 32'h22;
        AD3_D = ad3; RegWrite_D = 1'b1; MemRead_D = mr;
        AD3_M = '0; RegWrite_M = 1'b0; ALUout_M = '0;
        AD3_W = '0; RegWrite_W = 1'b0; WD3_W = '0; Flush_E = 1'b0;
    endtask

    task automatic apply(input vec_t v);
        Valid_D = v.vld; AD1_D = v.ad1; AD2_D = v.ad2; RD1_D = v.rd1; RD2_D = v.rd2;
        AD3_D = v.ad3; RegWrite_D = v.rw; MemRead_D = v.mr;
        AD3_M = v.ad3_m; RegWrite_M = v.rw_m; ALUout_M = v.alu_m;
        AD3_W = v.ad3_w; RegWrite_W = v.rw_w; WD3_W = v.wd3_w; Flush_E = v.flush;
    endtask

    initial begin
        //         vld   ad1   ad2   rd1     rd2     ad3    rw    mr    ad3_m rw_m  alu_m   ad3_w rw_w  wd3_w   flush  stall vld   a       b       ad3    rw    mr    cnt
        vecs[0]  = '{1'b1,5'd1, 5'd2, 32'h11, 32'h22, 5'd4,  1'b1, 1'b0, 5'd0, 1'b0, 32'h0,  5'd0, 1'b0, 32'h0,  1'b0,  1'b0, 1'b1, 32'h11, 32'h22, 5'd4,  1'b1, 1'b0, 16'd0};
        vecs[1]  = '{1'b1,5'd3, 5'd2, 32'h5,  32'h22, 5'd6,  1'b1, 1'b0, 5'd3, 1'b1, 32'hAA, 5'd0, 1'b0, 32'h0,  1'b0,  1'b0, 1'b1, 32'hAA, 32'h22, 5'd6,  1'b1, 1'b0, 16'd0};
        vecs[2]  = '{1'b1,5'd3, 5'd2, 32'h5,  32'h22, 5'd6,  1'b1, 1'b0, 5'd3, 1'b1, 32'hAA, 5'd3, 1'b1, 32'hBB, 1'b0,  1'b0, 1'b1, 32'hAA, 32'h22, 5'd6,  1'b1, 1'b0, 16'd0};
        vecs[3]  = '{1'b1,5'd1, 5'd7, 32'h11, 32'h99, 5'd8,  1'b1, 1'b0, 5'd8, 1'b1, 32'hAA, 5'd7, 1'b1, 32'h77, 1'b0,  1'b0, 1'b1, 32'h11, 32'h77, 5'd8,  1'b1, 1'b0, 16'd0};
        vecs[4]  = '{1'b1,5'd0, 5'd0, 32'h0,  32'h0,  5'd9,  1'b1, 1'b0, 5'd0, 1'b1, 32'hAA, 5'd0, 1'b1, 32'hBB, 1'b0,  1'b0, 1'b1, 32'h0,  32'h0,  5'd9,  1'b1, 1'b0, 16'd0};
        vecs[5]  = '{1'b0,5'd1, 5'd2, 32'h31, 32'h32, 5'd10, 1'b1, 1'b1, 5'd0, 1'b0, 32'h0,  5'd0, 1'b0, 32'h0,  1'b0,  1'b0, 1'b0, 32'h31, 32'h32, 5'd10, 1'b0, 1'b0, 16'd0};
        vecs[6]  = '{1'b1,5'd1, 5'd2, 32'h11, 32'h22, 5'd5,  1'b1, 1'b1, 5'd0, 1'b0, 32'h0,  5'd0, 1'b0, 32'h0,  1'b0,  1'b0, 1'b1, 32'h11, 32'h22, 5'd5,  1'b1, 1'b1, 16'd0};
        vecs[7]  = '{1'b1,5'd1, 5'd5, 32'h11, 32'h55, 5'd6,  1'b1, 1'b0, 5'd0, 1'b0, 32'h0,  5'd0, 1'b0, 32'h0,  1'b0,  1'b1, 1'b0, 32'h0,  32'h0,  5'd0,  1'b0, 1'b0, 16'd1};
        vecs[8]  = '{1'b1,5'd1, 5'd5, 32'h11, 32'h55, 5'd6,  1'b1, 1'b0, 5'd0, 1'b0, 32'h0,  5'd5, 1'b1, 32'h77, 1'b0,  1'b0, 1'b1, 32'h11, 32'h77, 5'd6,  1'b1, 1'b0, 16'd1};
        vecs[9]  = '{1'b1,5'd1, 5'd2, 32'h11, 32'h22, 5'd5,  1'b1, 1'b1, 5'd0, 1'b0, 32'h0,  5'd0, 1'b0, 32'h0,  1'b0,  1'b0, 1'b1, 32'h11, 32'h22, 5'd5,  1'b1, 1'b1, 16'd1};
        vecs[10] = '{1'b1,5'd5, 5'd2, 32'h55, 32'h22, 5'd6,  1'b1, 1'b0, 5'd0, 1'b0, 32'h0,  5'd0, 1'b0, 32'h0,  1'b1,  1'b0, 1'b0, 32'h0,  32'h0,  5'd0,  1'b0, 1'b0, 16'd1};
        vecs[11] = '{1'b1,5'd1, 5'd2, 32'h11, 32'h22, 5'd0,  1'b1, 1'b1, 5'd0, 1'b0, 32'h0,  5'd0, 1'b0, 32'h0,  1'b0,  1'b0, 1'b1, 32'h11, 32'h22, 5'd0,  1'b1, 1'b1, 16'd1};
        vecs[12] = '{1'b1,5'd0, 5'd0, 32'h0,  32'h0,  5'd3,  1'b1, 1'b0, 5'd0, 1'b0, 32'h0,  5'd0, 1'b0, 32'h0,  1'b0,  1'b0, 1'b1, 32'h0,  32'h0,  5'd3,  1'b1, 1'b0, 16'd1};
        vecs[13] = '{1'b1,5'd1, 5'd2, 32'h11, 32'h22, 5'd5,  1'b1, 1'b1, 5'd0, 1'b0, 32'h0,  5'd0, 1'b0, 32'h0,  1'b0,  1'b0, 1'b1, 32'h11, 32'h22, 5'd5,  1'b1, 1'b1, 16'd1};
        vecs[14] = '{1'b0,5'd1, 5'd5, 32'h11, 32'h55, 5'd6,  1'b1, 1'b0, 5'd0, 1'b0, 32'h0,  5'd0, 1'b0, 32'h0,  1'b0,  1'b0, 1'b0, 32'h11, 32'h55, 5'd6,  1'b0, 1'b0, 16'd1};
        vecs[15] = '{1'b1,5'd1, 5'd2, 32'h11, 32'h22, 5'd5,  1'b1, 1'b1, 5'd0, 1'b0, 32'h0,  5'd0, 1'b0, 32'h0,  1'b0,  1'b0, 1'b1, 32'h11, 32'h22, 5'd5,  1'b1, 1'b1, 16'd1};
        vecs[16] = '{1'b1,5'd5, 5'd2, 32'h55, 32'h22, 5'd6,  1'b1, 1'b0, 5'd0, 1'b0, 32'h0,  5'd0, 1'b0, 32'h0,  1'b0,  1'b1, 1'b0, 32'h0,  32'h0,  5'd0,  1'b0, 1'b0, 16'd2};

        rst_n = 1'b0;
        drive(1'b1, 5'd1, 5'd2, 5'd4, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        check("reset Valid_E", {31'd0, Valid_E}, 32'd0);
        check("reset SrcA_E", SrcA_E, 32'd0);
        check("reset StallCount", {16'd0, StallCount}, 32'd0);
        check("reset Stall_D", {31'd0, Stall_D}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < NV; i++) begin
            apply(vecs[i]);
            #1;
            check($sformatf("v%0d Stall_D", i), {31'd0, Stall_D}, {31'd0, vecs[i].x_stall});
            @(posedge clk);
            #1;
            check($sformatf("v%0d Valid_E", i), {31'd0, Valid_E}, {31'd0, vecs[i].x_vld});
            check($sformatf("v%0d SrcA_E", i), SrcA_E, vecs[i].x_a);
            check($sformatf("v%0d SrcB_E", i), SrcB_E, vecs[i].x_b);
            check($sformatf("v%0d AD3_E", i), {27'd0, AD3_E}, {27'd0, vecs[i].x_ad3});
            check($sformatf("v%0d RegWrite_E", i), {31'd0, RegWrite_E}, {31'd0, vecs[i].x_rw});
            check($sformatf("v%0d MemRead_E", i), {31'd0, MemRead_E}, {31'd0, vecs[i].x_mr});
            check($sformatf("v%0d StallCount", i), {16'd0, StallCount}, {16'd0, vecs[i].x_cnt});
        end

        // Reset asserted between edges must clear state without a clock.
        drive(1'b1, 5'd1, 5'd2, 5'd4, 1'b1);
        @(posedge clk);
        #1;
        check("pre-reset Valid_E", {31'd0, Valid_E}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async Valid_E", {31'd0, Valid_E}, 32'd0);
        check("async SrcA_E", SrcA_E, 32'd0);
        check("async SrcB_E", SrcB_E, 32'd0);
        check("async AD3_E", {27'd0, AD3_E}, 32'd0);
        check("async RegWrite_E", {31'd0, RegWrite_E}, 32'd0);
        check("async MemRead_E", {31'd0, MemRead_E}, 32'd0);
        check("async StallCount", {16'd0, StallCount}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post-reset Valid_E", {31'd0, Valid_E}, 32'd1);
        check("post-reset SrcA_E", SrcA_E, 32'h11);
        check("post-reset AD3_E", {27'd0, AD3_E}, 32'd4);
        check("post-reset MemRead_E", {31'd0, MemRead_E}, 32'd1);

        // Saturation: 14 stalls bring the 4-bit counter to 14, three more must pin it at 15.
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 17; i++) begin
            drive(1'b1, 5'd1, 5'd2, 5'd5, 1'b1);
            @(posedge clk);
            #1;
            drive(1'b1, 5'd1, 5'd5, 5'd6, 1'b0);
            #1;
            check($sformatf("sat%0d Stall_D", i), {31'd0, Stall_D}, 32'd1);
            @(posedge clk);
            #1;
            if (i == 13) begin
                check("sat14 small StallCount", {28'd0, s_stallcount}, 32'd14);
                check("sat14 StallCount", {16'd0, StallCount}, 32'd14);
            end
        end
        check("sat small StallCount", {28'd0, s_stallcount}, 32'd15);
        check("sat StallCount", {16'd0, StallCount}, 32'd17);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
